// File: rtl/sync_dualport_ram.sv
// sync_dualport_ram: single-clock simple dual-port RAM (one write, one read port).
// After every reset a zero-fill sequencer clears the array while busy is high.
// Reads return registered data with a one-cycle rd_valid strobe. A read and a
// write to the same in-range address in the same cycle return the new data
// (write-first). Out-of-range requests raise the sticky addr_err flag.
// Optional feature macro: SDPR_OUTREG_EN adds a second output register stage,
// which makes the read latency two edges. rd_valid stays aligned with data_out.
module sync_dualport_ram #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              write,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  data_in,
  input  logic              read,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  data_out,
  output logic              rd_valid,
  output logic              busy,
  output logic              addr_err
);

  typedef enum logic {
    INIT,
    READY
  } state_t;

  // DEPTH is widened by one bit so that the range check also works when DEPTH == 2**ADDR_W.
  localparam logic [ADDR_W:0]   DEPTH_W = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  logic [WIDTH-1:0]  mem [DEPTH];

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] cnt;

  logic              wr_ok;
  logic              rd_ok;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [WIDTH-1:0]  mem_wdata;
  logic              rd_fire;
  logic [WIDTH-1:0]  rd_word;
  logic              err_hit;

  logic              rd_v1;
  logic [WIDTH-1:0]  rd_d1;

  // State register. It restarts the zero-fill on every reset.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= INIT;
    else     state <= state_nx;
  end

  // Next state and port decode: zero-fill writes, range checks, read mux with write-first bypass.
  always_comb begin
    state_nx  = state;
    wr_ok     = ({1'b0, wr_addr} < DEPTH_W);
    rd_ok     = ({1'b0, rd_addr} < DEPTH_W);
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = data_in;
    rd_fire   = 1'b0;
    rd_word   = '0;
    err_hit   = 1'b0;
    case (state)
      INIT: begin
        mem_we    = 1'b1;
        mem_waddr = cnt;
        mem_wdata = '0;
        if (cnt == LAST) state_nx = READY;
      end
      READY: begin
        mem_we  = write && wr_ok;
        rd_fire = read;
        if (read && rd_ok) begin
          if (write && (wr_addr == rd_addr)) rd_word = data_in;
          else                               rd_word = mem[rd_addr];
        end
        err_hit = (write && !wr_ok) || (read && !rd_ok);
      end
      default: state_nx = INIT;
    endcase
  end

  // Fill counter. It walks 0..DEPTH-1 during INIT and parks at 0 afterwards.
  always_ff @(posedge clk or posedge clr) begin
    if (clr)                cnt <= '0;
    else if (state == INIT) cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
  end

  // Storage array, with no reset so that it maps onto RAM; INIT performs the clearing.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // First output stage: loads on a read and holds its data otherwise. rd_v1 is a single-cycle strobe.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      rd_v1 <= 1'b0;
      rd_d1 <= '0;
    end else begin
      rd_v1 <= rd_fire;
      if (rd_fire) rd_d1 <= rd_word;
    end
  end

  // Sticky error flag. Only clr can clear it.
  always_ff @(posedge clk or posedge clr) begin
    if (clr)          addr_err <= 1'b0;
    else if (err_hit) addr_err <= 1'b1;
  end

`ifdef SDPR_OUTREG_EN
  logic             rd_v2;
  logic [WIDTH-1:0] rd_d2;

  // Second output stage: copies stage one every cycle, so throughput stays at one read per cycle.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      rd_v2 <= 1'b0;
      rd_d2 <= '0;
    end else begin
      rd_v2 <= rd_v1;
      rd_d2 <= rd_d1;
    end
  end

  assign data_out = rd_d2;
  assign rd_valid = rd_v2;
`else
  assign data_out = rd_d1;
  assign rd_valid = rd_v1;
`endif

  assign busy = (state == INIT);

endmodule

// File: tb/tb_sync_dualport_ram.sv
// Testbench for sync_dualport_ram. It applies directed vectors with hand-computed expectations.
// One instance uses DEPTH=16 for the main function. A second instance uses DEPTH=12
// for the out-of-range cases. Handles the SDPR_OUTREG_EN latency through LAT.
module tb_sync_dualport_ram;

`ifdef SDPR_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        clr;

  logic        write16, read16;
  logic [3:0]  wa16, ra16;
  logic [15:0] di16, do16;
  logic        v16, busy16, err16;

  logic        write12, read12;
  logic [3:0]  wa12, ra12;
  logic [15:0] di12, do12;
  logic        v12, busy12, err12;

  int assertionCount = 0;
  int failCount      = 0;
  int busyEdges;
  int validDuringBusy;
  logic [15:0] expB2b [3];

  sync_dualport_ram #(.WIDTH(16), .DEPTH(16), .ADDR_W(4)) u16 (
    .clk(clk), .clr(clr), .write(write16), .wr_addr(wa16), .data_in(di16),
    .read(read16), .rd_addr(ra16), .data_out(do16), .rd_valid(v16),
    .busy(busy16), .addr_err(err16)
  );

  sync_dualport_ram #(.WIDTH(16), .DEPTH(12), .ADDR_W(4)) u12 (
    .clk(clk), .clr(clr), .write(write12), .wr_addr(wa12), .data_in(di12),
    .read(read12), .rd_addr(ra12), .data_out(do12), .rd_valid(v12),
    .busy(busy12), .addr_err(err12)
  );

  // Free-running clock with a 10 ns period.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    assertionCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", tag, got, exp);
    end
  endtask

  // Waits for the next falling edge, then drives one instance. The other instance is left idle.
  task automatic applyStimulus(input logic sel, input logic w, input logic [3:0] wa,
                               input logic [15:0] di, input logic r, input logic [3:0] ra);
    @(negedge clk);
    write16 = 1'b0; wa16 = 4'd0; di16 = 16'd0; read16 = 1'b0; ra16 = 4'd0;
    write12 = 1'b0; wa12 = 4'd0; di12 = 16'd0; read12 = 1'b0; ra12 = 4'd0;
    if (sel == 1'b0) begin
      write16 = w; wa16 = wa; di16 = di; read16 = r; ra16 = ra;
    end else begin
      write12 = w; wa12 = wa; di12 = di; read12 = r; ra12 = ra;
    end
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, 4'd0, 16'd0, 1'b0, 4'd0);
  endtask

  task automatic readCheck(input string tag, input logic sel, input logic [3:0] addr,
                           input logic [15:0] exp);
    applyStimulus(sel, 1'b0, 4'd0, 16'd0, 1'b1, addr);
    repeat (LAT) idleCycle();
    if (sel == 1'b0) begin
      checkOutput({tag, "_data"}, do16, exp);
      checkOutput({tag, "_valid"}, {15'd0, v16}, 16'd1);
    end else begin
      checkOutput({tag, "_data"}, do12, exp);
      checkOutput({tag, "_valid"}, {15'd0, v12}, 16'd1);
    end
  endtask

  // Counts the edges spent busy on u16 after clr release. The loop is bounded so that the bench cannot hang.
  task automatic countBusy();
    busyEdges = 0;
    validDuringBusy = 0;
    while (busy16 && busyEdges < 100) begin
      @(negedge clk);
      busyEdges++;
      if (v16) validDuringBusy++;
    end
    write16 = 1'b0; read16 = 1'b0;
  endtask

  // Main directed sequence.
  initial begin
    clr = 1'b1;
    write16 = 1'b0; wa16 = 4'd0; di16 = 16'd0; read16 = 1'b0; ra16 = 4'd0;
    write12 = 1'b0; wa12 = 4'd0; di12 = 16'd0; read12 = 1'b0; ra12 = 4'd0;
    repeat (2) @(negedge clk);

    $display("[TB] reset state");
    checkOutput("rst_data",  do16, 16'h0000);
    checkOutput("rst_valid", {15'd0, v16},    16'd0);
    checkOutput("rst_busy",  {15'd0, busy16}, 16'd1);
    checkOutput("rst_err",   {15'd0, err16},  16'd0);

    $display("[TB] zero-fill with requests driven during busy");
    clr = 1'b0;
    write16 = 1'b1; wa16 = 4'd5; di16 = 16'hBEEF; read16 = 1'b1; ra16 = 4'd5;
    countBusy();
    checkOutput("busy_edges", 16'(busyEdges), 16'd16);
    checkOutput("busy_novalid", 16'(validDuringBusy), 16'd0);
    checkOutput("busy_err", {15'd0, err16}, 16'd0);
    for (int a = 0; a < 16; a++) begin
      readCheck($sformatf("fill%0d", a), 1'b0, 4'(a), 16'h0000);
    end

    $display("[TB] write then read, valid strobe, hold");
    applyStimulus(1'b0, 1'b1, 4'd3, 16'hA5A5, 1'b0, 4'd0);
    readCheck("wr3", 1'b0, 4'd3, 16'hA5A5);
    idleCycle();
    checkOutput("hold_data",  do16, 16'hA5A5);
    checkOutput("hold_valid", {15'd0, v16}, 16'd0);

    $display("[TB] write-first collision");
    applyStimulus(1'b0, 1'b1, 4'd7, 16'h1234, 1'b1, 4'd7);
    repeat (LAT) idleCycle();
    checkOutput("coll_data",  do16, 16'h1234);
    checkOutput("coll_valid", {15'd0, v16}, 16'd1);
    readCheck("coll_mem", 1'b0, 4'd7, 16'h1234);

    $display("[TB] boundary addresses and back-to-back reads");
    applyStimulus(1'b0, 1'b1, 4'd0,  16'h0F0F, 1'b0, 4'd0);
    applyStimulus(1'b0, 1'b1, 4'd15, 16'hF00F, 1'b0, 4'd0);
    expB2b[0] = 16'h0F0F; expB2b[1] = 16'hF00F; expB2b[2] = 16'hA5A5;
    for (int k = 0; k <= 2 + LAT; k++) begin
      if (k == 0)      applyStimulus(1'b0, 1'b0, 4'd0, 16'd0, 1'b1, 4'd0);
      else if (k == 1) applyStimulus(1'b0, 1'b0, 4'd0, 16'd0, 1'b1, 4'd15);
      else if (k == 2) applyStimulus(1'b0, 1'b0, 4'd0, 16'd0, 1'b1, 4'd3);
      else             idleCycle();
      if (k >= LAT) begin
        checkOutput($sformatf("b2b%0d_data", k - LAT), do16, expB2b[k - LAT]);
        checkOutput($sformatf("b2b%0d_valid", k - LAT), {15'd0, v16}, 16'd1);
      end
    end
    checkOutput("main_err", {15'd0, err16}, 16'd0);

    $display("[TB] DEPTH=12 range checks");
    checkOutput("d12_err0", {15'd0, err12}, 16'd0);
    applyStimulus(1'b1, 1'b1, 4'd11, 16'h1111, 1'b0, 4'd0);
    readCheck("d12_last", 1'b1, 4'd11, 16'h1111);
    checkOutput("d12_err_last", {15'd0, err12}, 16'd0);
    applyStimulus(1'b1, 1'b1, 4'd13, 16'hFFFF, 1'b0, 4'd0);
    idleCycle();
    checkOutput("d12_err_wr", {15'd0, err12}, 16'd1);
    readCheck("d12_oor13", 1'b1, 4'd13, 16'h0000);
    readCheck("d12_last2", 1'b1, 4'd11, 16'h1111);
    readCheck("d12_oor12", 1'b1, 4'd12, 16'h0000);
    repeat (3) idleCycle();
    checkOutput("d12_err_sticky", {15'd0, err12}, 16'd1);

    $display("[TB] clr during an active read");
    applyStimulus(1'b0, 1'b0, 4'd0, 16'd0, 1'b1, 4'd3);
    repeat (LAT) idleCycle();
    checkOutput("pre_clr_valid", {15'd0, v16}, 16'd1);
    #1 clr = 1'b1;
    #1;
    checkOutput("clr_data",  do16, 16'h0000);
    checkOutput("clr_valid", {15'd0, v16},    16'd0);
    checkOutput("clr_busy",  {15'd0, busy16}, 16'd1);
    checkOutput("clr_err12", {15'd0, err12},  16'd0);
    @(negedge clk);
    clr = 1'b0;
    countBusy();
    checkOutput("rerun_busy_edges", 16'(busyEdges), 16'd16);
    readCheck("rerun_a3", 1'b0, 4'd3, 16'h0000);
    readCheck("rerun_a7", 1'b0, 4'd7, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", assertionCount, failCount);
    $finish;
  end

endmodule
